quad_ud_decoder: RTL and testbench
==================================

Name: quad_ud_decoder

Overview:
- Quadrature front end that produces the direction/step stream consumed by the lab up/down counter.
- Takes raw A/B phase inputs from a rotary encoder or switches, then synchronizes and debounces them.
- Decodes Gray-code transitions into a one-cycle step pulse plus a UD direction level.
- Keeps its own wrapping position count driven onto LED[3:0].

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized input must differ from its filtered value before the change is accepted. Legal range is 1 to 255.
- CNT_W, 4: width of the position count and the LED output.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of the count and the error flag; active high.
- A  input  1  raw phase A; asynchronous to clk.
- B  input  1  raw phase B; asynchronous to clk.
- step  output  1  one-cycle pulse per valid transition.
- UD  output  1  direction of the last valid step; 1 = up, 0 = down.
- err  output  1  sticky flag for an illegal transition (both phases changed at once).
- LED  output  CNT_W  position count.

Behaviour:
- Reset (reset=0, asynchronous):
  - Sync flops, filter counters and filtered values go to 0.
  - step=0, UD=1, err=0, LED=0.
  - init flag is set.
- Synchronization: A and B each pass through 2 flops before any logic uses them.
- Filter (per channel):
  - Counter clears whenever the synchronized value equals the filtered value.
  - Counter increments while the two differ.
  - Filtered value takes the synchronized value on the edge where the counter would reach DEBOUNCE_CYCLES; the counter then clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is never accepted.
- Latency:
  - New level first sampled at edge k gives filtered update at edge k+1+DEBOUNCE_CYCLES.
  - step/UD/LED update at edge k+2+DEBOUNCE_CYCLES.
  - With the default (4), the response lands 6 edges after k.
- Decode (registered; prev = last decoded {A,B}, cur = filtered {A,B}):
  - Up sequence: 00 -> 10 -> 11 -> 01 -> 00. A valid step in this direction sets step=1, UD=1, LED+1.
  - Down sequence: the reverse. A valid step sets step=1, UD=0, LED-1.
  - cur == prev: no action; step=0.
  - Both bits changed: err pulses to sticky 1; no step, UD held, LED held. prev is still updated to cur.
- Count wraps modulo 2^CNT_W:
  - Up at 15 gives 0.
  - Down at 0 gives 15.
- step is high for exactly one cycle per transition. UD holds between steps.
- init flag (first filtered state after reset):
  - The first filtered state change is loaded into prev without decoding, so a non-00 encoder rest position never raises err or steps.
  - init clears on the first filtered update, or after 2+DEBOUNCE_CYCLES cycles with no change, whichever comes first.
- clr:
  - Forces LED=0 and err=0 on the next edge.
  - Wins over a simultaneous step: LED=0 and step is still pulsed, UD updated.
  - Does not reset the filters or prev.
- If A and B filtered changes land on the same edge, this is treated as a double change, i.e. an err.
- Reset asserted mid-debounce or mid-step: all state returns to reset values immediately. No partial step is emitted after release.

Decomposition:
- Shared package quad_pkg:
  - Gray-state constants S00, S10, S11, S01.
  - Direction constants DIR_UP=1, DIR_DN=0.
  - A function returning {valid, dir, illegal} from (prev, cur).
- One sub-module, quad_filter: 2-flop synchronizer plus debounce counter for one channel, parameterized by DEBOUNCE_CYCLES, instantiated twice.
- The top holds the decode, init, count and err logic.

Test Plan:
- Reset sequence (reset 1 -> 0 for 10 ns -> 1, A=B=0) -> LED=0, UD=1, err=0, step=0 throughout and after release.
- Drive A,B through 00,10,11,01,00 with 20 clocks per state -> 4 step pulses, each 1 cycle wide, UD=1, LED 0->4. Each step arrives 6 edges after its input change is first sampled.
- From LED=0, drive the reverse sequence 00,01,11,10,00 -> LED 15,14,13,12, UD=0, no err. This confirms the down wrap.
- Pulse A high for 3 cycles only (DEBOUNCE_CYCLES=4) -> no step, LED unchanged, filter never updates. A 4-cycle pulse is accepted.
- Jump A,B from 00 to 11 in one cycle and hold -> err=1 and sticky, LED and UD unchanged, no step. Then clr=1 for one cycle -> err=0, LED=0.
- Hold A=B=1 through reset release -> no err, no step. The next 11->01 transition gives UD=1, LED=1.

Source files
------------

// File: rtl/quad_ud_decoder_pkg.sv
// Shared constants and the Gray-code transition classifier for the quadrature decoder.
package quad_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S10 = 2'b10,
    S11 = 2'b11,
    S01 = 2'b01
  } gray_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef struct packed {
    logic valid;
    logic dir;
    logic illegal;
  } dec_t;

  // Position of a {A,B} state along the up sequence 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] gray_idx(input logic [1:0] g);
    logic [1:0] idx;
    case (g)
      S00:     idx = 2'd0;
      S10:     idx = 2'd1;
      S11:     idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  function automatic dec_t quad_decode(input logic [1:0] prev, input logic [1:0] cur);
    dec_t       r;
    logic [1:0] d;
    d         = gray_idx(cur) - gray_idx(prev);
    r.valid   = (d == 2'd1) || (d == 2'd3);
    r.dir     = (d == 2'd1) ? DIR_UP : DIR_DN;
    r.illegal = (d == 2'd2);
    return r;
  endfunction

endpackage

// File: rtl/quad_ud_decoder_filter.sv
// Two-flop synchronizer followed by a debounce counter for one encoder phase.
module quad_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic       s1, s2;
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) begin
        cnt <= '0;
      end else if (cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
        // Accept on the edge where the count would reach DEBOUNCE_CYCLES.
        dout <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/quad_ud_decoder.sv
// Quadrature front end: filtered A/B phases decoded into step/UD pulses and a wrapping count.
module quad_ud_decoder
  import quad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             A,
  input  logic             B,
  output logic             step,
  output logic             UD,
  output logic             err,
  output logic [CNT_W-1:0] LED
);

  localparam logic [8:0] INIT_CYC = 9'(DEBOUNCE_CYCLES + 2);

  logic       fa, fb;
  logic [1:0] cur, prev;
  logic       init;
  logic [8:0] tmr;
  dec_t       dec;

  quad_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fa (
    .clk(clk), .reset(reset), .din(A), .dout(fa)
  );

  quad_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fb (
    .clk(clk), .reset(reset), .din(B), .dout(fb)
  );

  always_comb begin
    cur = {fa, fb};
    dec = quad_decode(prev, cur);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev <= S00;
      init <= 1'b1;
      tmr  <= '0;
      step <= 1'b0;
      UD   <= DIR_UP;
      err  <= 1'b0;
      LED  <= '0;
    end else begin
      step <= 1'b0;
      if (init) begin
        // The first filtered state only seeds prev, so a non-00 rest position is silent.
        if (cur != prev) begin
          prev <= cur;
          init <= 1'b0;
        end else if (tmr == INIT_CYC) begin
          init <= 1'b0;
        end else begin
          tmr <= tmr + 9'd1;
        end
      end else if (cur != prev) begin
        prev <= cur;
        if (dec.illegal) begin
          err <= 1'b1;
        end else if (dec.valid) begin
          step <= 1'b1;
          UD   <= dec.dir;
          LED  <= (dec.dir == DIR_UP) ? LED + CNT_W'(1) : LED - CNT_W'(1);
        end
      end
      if (clr) begin
        LED <= '0;
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_ud_decoder.sv
// Scoreboard bench: each driven transition queues its expected step, checked when step fires.
module tb_quad_ud_decoder;

  logic       clk, reset, clr, A, B;
  logic       step, UD, err;
  logic [3:0] LED;

  typedef struct {
    int unsigned cyc;
    logic        ud;
    logic [3:0]  led;
  } exp_t;

  exp_t        q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  logic [3:0]  eled  = 4'd0;
  bit          mon_en = 1'b0;

  quad_ud_decoder #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .clr(clr), .A(A), .B(B),
    .step(step), .UD(UD), .err(err), .LED(LED)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive {A,B} at a falling edge and hold for n cycles; a valid step lands 7 posedges later.
  task automatic drive(input logic a, input logic b, input int n,
                       input bit exp_step, input logic ud);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    if (exp_step) begin
      if (ud) eled = eled + 4'd1;
      else    eled = eled - 4'd1;
      e.cyc = cyc + 7;
      e.ud  = ud;
      e.led = eled;
      q.push_back(e);
    end
    repeat (n - 1) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && step === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_step", step, 1'b0);
      end else begin
        e = q.pop_front();
        chk("step_cyc", cyc, e.cyc);
        chk("step_ud", UD, e.ud);
        chk("step_led", LED, e.led);
      end
    end
  end

  initial begin
    reset = 1'b1; clr = 1'b0; A = 1'b0; B = 1'b0;

    // Reset with A=B=0
    #3 reset = 1'b0;
    #1;
    chk("rst_led", LED, 4'd0);
    chk("rst_ud", UD, 1'b1);
    chk("rst_err", err, 1'b0);
    chk("rst_step", step, 1'b0);
    #9 reset = 1'b1;
    mon_en = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_led", LED, 4'd0);
    chk("post_rst_ud", UD, 1'b1);
    chk("post_rst_err", err, 1'b0);

    // Up sequence
    drive(1'b1, 1'b0, 20, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 20, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 20, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 20, 1'b1, 1'b1);
    chk("up_led", LED, 4'd4);
    chk("up_ud", UD, 1'b1);
    chk("up_err", err, 1'b0);

    // Clear to 0, then down sequence wraps below zero
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    eled = 4'd0;
    chk("clr_led", LED, 4'd0);
    drive(1'b0, 1'b1, 20, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 20, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 20, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 20, 1'b1, 1'b0);
    chk("dn_led", LED, 4'd12);
    chk("dn_ud", UD, 1'b0);
    chk("dn_err", err, 1'b0);

    // 3-cycle glitch rejected, 4-cycle pulse accepted (up then back down)
    drive(1'b1, 1'b0, 3, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 20, 1'b0, 1'b0);
    chk("glitch_led", LED, 4'd12);
    chk("glitch_filt", dut.u_fa.dout, 1'b0);
    drive(1'b1, 1'b0, 4, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 20, 1'b1, 1'b0);
    chk("pulse4_led", LED, 4'd12);

    // Double change raises sticky err; clr recovers
    drive(1'b1, 1'b1, 20, 1'b0, 1'b0);
    chk("dbl_err", err, 1'b1);
    chk("dbl_led", LED, 4'd12);
    chk("dbl_ud", UD, 1'b0);
    repeat (10) @(negedge clk);
    chk("dbl_err_sticky", err, 1'b1);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    eled = 4'd0;
    chk("clr_err", err, 1'b0);
    chk("clr_led2", LED, 4'd0);

    // Reset with A=B=1 held: rest position is absorbed silently
    @(negedge clk) reset = 1'b0;
    #1;
    chk("rst2_led", LED, 4'd0);
    chk("rst2_ud", UD, 1'b1);
    chk("rst2_err", err, 1'b0);
    @(negedge clk) reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst11_err", err, 1'b0);
    chk("rst11_led", LED, 4'd0);
    drive(1'b0, 1'b1, 20, 1'b1, 1'b1);
    chk("rst11_step_led", LED, 4'd1);
    chk("rst11_step_ud", UD, 1'b1);
    chk("rst11_step_err", err, 1'b0);

    chk("sb_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
